// File: rtl/edge_byte_packer.sv
// Binarises an edge-magnitude pixel stream to 1 bit/pixel and packs 8 pixels per byte, row-aligned.
// Each frame is wrapped in SOF/EOF marker bytes, and the result drains through a show-ahead FIFO.
module edge_byte_packer #(
  parameter int          H_RES      = 172,
  parameter int          V_RES      = 240,
  parameter int          THRESHOLD  = 128,
  parameter int          FIFO_DEPTH = 64,
  parameter logic [7:0]  SOF_BYTE   = 8'hA5,
  parameter logic [7:0]  EOF_BYTE   = 8'h5A
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_de,
  input  logic [7:0] i_data,
  input  logic       i_ready,
  output logic       o_valid,
  output logic [7:0] o_byte,
  output logic       o_frame_done,
  output logic       o_overflow
);

  localparam int XW = $clog2(H_RES);
  localparam int YW = $clog2(V_RES);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [8:0] THR = 9'(THRESHOLD);

  logic [XW-1:0] x;
  logic [YW-1:0] y;
  logic [2:0]    bit_cnt;
  logic [7:0]    acc;
  logic          eof_pend;
  logic          sof_pend;

  logic          pix_bit;
  logic [7:0]    bit_mask;
  logic [7:0]    data_byte;
  logic          x_last;
  logic          y_last;
  logic          data_push;
  logic          frame_start;
  logic          frame_end;

  assign pix_bit     = ({1'b0, i_data} >= THR);
  assign bit_mask    = 8'h80 >> bit_cnt;
  assign data_byte   = pix_bit ? (acc | bit_mask) : acc;
  assign x_last      = (x == XW'(H_RES - 1));
  assign y_last      = (y == YW'(V_RES - 1));
  assign data_push   = i_de && ((bit_cnt == 3'd7) || x_last);
  assign frame_start = i_de && (x == '0) && (y == '0);
  assign frame_end   = i_de && x_last && y_last;

  // Push arbitration, one FIFO write per cycle. EOF of the previous frame wins;
  // an SOF that collides with it is deferred one cycle.
  logic       push;
  logic [8:0] push_word;  // {is_eof, byte}
  logic       sof_defer;

  always_comb begin
    push      = 1'b0;
    push_word = '0;
    sof_defer = 1'b0;
    if (eof_pend) begin
      push      = 1'b1;
      push_word = {1'b1, EOF_BYTE};
      sof_defer = frame_start;
    end else if (sof_pend || frame_start) begin
      push      = 1'b1;
      push_word = {1'b0, SOF_BYTE};
    end else if (data_push) begin
      push      = 1'b1;
      push_word = {1'b0, data_byte};
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      x        <= '0;
      y        <= '0;
      bit_cnt  <= '0;
      acc      <= '0;
      eof_pend <= 1'b0;
      sof_pend <= 1'b0;
    end else begin
      eof_pend <= frame_end;
      sof_pend <= sof_defer;
      if (i_de) begin
        x <= x_last ? '0 : x + XW'(1);
        if (x_last) y <= y_last ? '0 : y + YW'(1);
        if (data_push) begin
          acc     <= '0;
          bit_cnt <= '0;
        end else begin
          acc     <= data_byte;
          bit_cnt <= bit_cnt + 3'd1;
        end
      end
    end
  end

  // Show-ahead FIFO; the EOF tag travels with the byte so data equal to EOF_BYTE is harmless.
  logic [8:0]  mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          full;
  logic          pop;
  logic          wr_en;

  assign full    = (count == (AW+1)'(FIFO_DEPTH));
  assign o_valid = (count != '0);
  assign o_byte  = o_valid ? mem[rd_ptr][7:0] : 8'h00;
  assign pop     = o_valid && i_ready;
  assign wr_en   = push && (!full || pop);

  // NOTE: the storage array has no reset; the count and pointers alone define which entries are live.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= push_word;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      o_frame_done <= 1'b0;
      o_overflow   <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + AW'(1);
      if (pop)   rd_ptr <= rd_ptr + AW'(1);
      case ({wr_en, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
      o_frame_done <= pop && mem[rd_ptr][8];
      if (push && full && !pop) o_overflow <= 1'b1;
    end
  end

endmodule
